// File: rtl/ahb_user_seq_pkg.sv
// Shared types and address helpers for the AHB user-side burst sequencer.
// Burst codes, FSM states, beat-count and next-beat-address functions.
package ahb_user_pkg;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_WD
    } seq_state_e;

    // Command entry carries {len[7:0], write, size[2:0], burst[2:0]} above the address.
    localparam int CMD_META_W = 15;

    function automatic logic [1:0] eff_size(input logic [2:0] size);
        return (size > 3'd2) ? 2'd2 : size[1:0];
    endfunction

    function automatic logic [8:0] beats_from_burst(input hburst_e burst, input logic [7:0] len);
        logic [8:0] n;
        case (burst)
            HB_SINGLE:          n = 9'd1;
            HB_INCR:            n = {1'b0, len} + 9'd1;
            HB_WRAP4, HB_INCR4: n = 9'd4;
            HB_WRAP8, HB_INCR8: n = 9'd8;
            default:            n = 9'd16;
        endcase
        return n;
    endfunction

    function automatic logic is_wrap(input hburst_e burst);
        return (burst == HB_WRAP4) || (burst == HB_WRAP8) || (burst == HB_WRAP16);
    endfunction

    // Wrap windows never exceed 64 bytes, so only the low byte can wrap;
    // bit 8 of the result is the carry into the upper address bits.
    function automatic logic [8:0] next_beat_lo(input logic [7:0] lo, input hburst_e burst,
                                                input logic [1:0] size);
        logic [8:0] sum;
        logic [7:0] span;
        logic [7:0] mask;
        sum  = {1'b0, lo} + (9'd1 << size);
        span = 8'(beats_from_burst(burst, 8'd0) << size);
        mask = span - 8'd1;
        if (is_wrap(burst)) begin
            return {1'b0, (lo & ~mask) | (sum[7:0] & mask)};
        end
        return sum;
    endfunction

endpackage

// File: rtl/ahb_user_seq_fifo.sv
// Synchronous FIFO with registered occupancy count; used for commands and write beats.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     HRESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ahb_user_seq.sv
// Expands queued whole-burst commands into one user-interface beat per HREAdy cycle,
// pairing write beats with a separate write-data FIFO, and echoes read returns.
module ahb_user_seq
    import ahb_user_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int WD_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [2:0]            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic                  cmd_write,
    input  logic [7:0]            cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [data_width-1:0] wd_data,
    input  logic                  HREAdy,
    input  logic [data_width-1:0] HRUSER,
    input  logic                  read_valid,
    output logic [addr_width-1:0] HAUSER,
    output logic [data_width-1:0] HWUSER,
    output logic [2:0]            HSUSER,
    output logic [3:0]            HBUSER,
    output logic                  HWSUSER,
    output logic                  input_HB_valid,
    output logic                  input_data_valid,
    output logic                  rd_valid,
    output logic [data_width-1:0] rd_data,
    output logic                  busy
);

    localparam int CMD_W = addr_width + CMD_META_W;

    logic [CMD_W-1:0]             cmd_din;
    logic [CMD_W-1:0]             cmd_dout;
    logic                         cmd_full;
    logic                         cmd_empty;
    logic                         cmd_pop;
    logic [$clog2(CMD_DEPTH):0]   cmd_count;
    logic [data_width-1:0]        wd_dout;
    logic                         wd_full;
    logic                         wd_empty;
    logic                         wd_pop;
    logic [$clog2(WD_DEPTH):0]    wd_count;

    seq_state_e                   state;
    seq_state_e                   state_n;
    hburst_e                      b_burst;
    logic [1:0]                   b_size;
    logic                         b_write;
    logic [7:0]                   b_len;
    logic [8:0]                   beats_left;
    logic [addr_width-1:0]        cur_addr;
    logic [addr_width-1:0]        next_addr;
    logic [8:0]                   lo_next;
    logic                         fire;

    assign cmd_ready = !cmd_full && !HRESET;
    assign wd_ready  = !wd_full && !HRESET;
    assign cmd_din   = {cmd_len, cmd_write, cmd_size, cmd_burst, cmd_addr};

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .HRESET(HRESET),
        .push  (cmd_valid && cmd_ready),
        .pop   (cmd_pop),
        .din   (cmd_din),
        .dout  (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    sync_fifo #(.WIDTH(data_width), .DEPTH(WD_DEPTH)) u_wd_fifo (
        .clk   (clk),
        .HRESET(HRESET),
        .push  (wd_valid && wd_ready),
        .pop   (wd_pop),
        .din   (wd_data),
        .dout  (wd_dout),
        .full  (wd_full),
        .empty (wd_empty),
        .count (wd_count)
    );

    assign lo_next   = next_beat_lo(cur_addr[7:0], b_burst, b_size);
    assign next_addr = {cur_addr[addr_width-1:8] + {{(addr_width-9){1'b0}}, lo_next[8]},
                        lo_next[7:0]};

    // Retiring the last beat pops the next command straight into LOAD, leaving one bubble.
    always_comb begin
        state_n          = state;
        cmd_pop          = 1'b0;
        wd_pop           = 1'b0;
        fire             = 1'b0;
        input_HB_valid   = 1'b0;
        input_data_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: state_n = ST_ISSUE;
            ST_ISSUE: begin
                if (b_write && wd_empty) begin
                    state_n = ST_WAIT_WD;
                end else begin
                    input_HB_valid   = 1'b1;
                    input_data_valid = b_write;
                    fire             = HREAdy;
                    if (HREAdy) begin
                        wd_pop = b_write;
                        if (beats_left == 9'd1) begin
                            if (!cmd_empty) begin
                                cmd_pop = 1'b1;
                                state_n = ST_LOAD;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_WAIT_WD: begin
                if (!wd_empty) begin
                    state_n = ST_ISSUE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign HAUSER  = input_HB_valid ? cur_addr : '0;
    assign HWUSER  = input_data_valid ? wd_dout : '0;
    assign HSUSER  = input_HB_valid ? {1'b0, b_size} : 3'd0;
    assign HBUSER  = input_HB_valid ? {1'b0, b_burst} : 4'd0;
    assign HWSUSER = input_HB_valid && b_write;
    assign busy    = (state != ST_IDLE) || (cmd_count != '0) || (wd_count != '0);

    always_ff @(posedge clk) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            b_burst    <= HB_SINGLE;
            b_size     <= '0;
            b_write    <= 1'b0;
            b_len      <= '0;
            beats_left <= '0;
        end else begin
            state <= state_n;
            if (cmd_pop) begin
                cur_addr <= cmd_dout[addr_width-1:0];
                b_burst  <= hburst_e'(cmd_dout[addr_width+2:addr_width]);
                b_size   <= eff_size(cmd_dout[addr_width+5:addr_width+3]);
                b_write  <= cmd_dout[addr_width+6];
                b_len    <= cmd_dout[addr_width+14:addr_width+7];
            end else if (fire) begin
                cur_addr <= next_addr;
            end
            if (state == ST_LOAD) begin
                beats_left <= beats_from_burst(b_burst, b_len);
            end else if (fire) begin
                beats_left <= beats_left - 9'd1;
            end
        end
    end

    // Read return path is a plain pipeline stage, unrelated to the command FSM.
    always_ff @(posedge clk) begin
        if (HRESET) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= read_valid;
            if (read_valid) begin
                rd_data <= HRUSER;
            end
        end
    end

endmodule

// File: tb/tb_ahb_user_seq.sv
// Directed self-checking bench for ahb_user_seq with hand-computed beat expectations.
module tb_ahb_user_seq;

    logic        clk = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic        cmd_write;
    logic [7:0]  cmd_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        HREAdy;
    logic [31:0] HRUSER;
    logic        read_valid;
    logic [31:0] HAUSER;
    logic [31:0] HWUSER;
    logic [2:0]  HSUSER;
    logic [3:0]  HBUSER;
    logic        HWSUSER;
    logic        input_HB_valid;
    logic        input_data_valid;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] exp_w4 [4] = '{32'h14, 32'h18, 32'h1C, 32'h10};
    logic [31:0] exp_w8 [8] = '{32'h34, 32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};

    ahb_user_seq dut (
        .clk             (clk),
        .HRESET          (HRESET),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_burst       (cmd_burst),
        .cmd_size        (cmd_size),
        .cmd_write       (cmd_write),
        .cmd_len         (cmd_len),
        .wd_valid        (wd_valid),
        .wd_ready        (wd_ready),
        .wd_data         (wd_data),
        .HREAdy          (HREAdy),
        .HRUSER          (HRUSER),
        .read_valid      (read_valid),
        .HAUSER          (HAUSER),
        .HWUSER          (HWUSER),
        .HSUSER          (HSUSER),
        .HBUSER          (HBUSER),
        .HWSUSER         (HWSUSER),
        .input_HB_valid  (input_HB_valid),
        .input_data_valid(input_data_valid),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one command for one cycle; the caller guarantees cmd_ready.
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] burst, input logic [2:0] size,
                                 input logic wr, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_burst = burst;
        cmd_size  = size;
        cmd_write = wr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pushData(input logic [31:0] d);
        wd_valid = 1'b1;
        wd_data  = d;
        tick();
        wd_valid = 1'b0;
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] burst, input logic [2:0] size, input logic wr);
        checkOutput({tag, " valid"}, 32'(input_HB_valid), 32'd1);
        checkOutput({tag, " addr"}, HAUSER, addr);
        checkOutput({tag, " wdata"}, HWUSER, wr ? data : 32'd0);
        checkOutput({tag, " hbuser"}, 32'(HBUSER), {29'd0, burst});
        checkOutput({tag, " hsize"}, 32'(HSUSER), {29'd0, size});
        checkOutput({tag, " dir"}, 32'(HWSUSER), 32'(wr));
        checkOutput({tag, " dvalid"}, 32'(input_data_valid), 32'(wr));
        tick();
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " valid"}, 32'(input_HB_valid), 32'd0);
        checkOutput({tag, " dvalid"}, 32'(input_data_valid), 32'd0);
    endtask

    initial begin
        HRESET     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_burst  = '0;
        cmd_size   = '0;
        cmd_write  = 1'b0;
        cmd_len    = '0;
        wd_valid   = 1'b0;
        wd_data    = '0;
        HREAdy     = 1'b1;
        HRUSER     = '0;
        read_valid = 1'b0;

        // Reset state
        tick();
        checkOutput("rst cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst wd_ready", 32'(wd_ready), 32'd0);
        tick();
        checkIdle("rst");
        checkOutput("rst haddr", HAUSER, 32'd0);
        checkOutput("rst rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        HRESET = 1'b0;
        tick();
        checkOutput("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("post-rst wd_ready", 32'(wd_ready), 32'd1);

        // SINGLE write: beat appears two edges after the push
        pushData(32'd16);
        applyStimulus(32'h0, 3'd0, 3'd2, 1'b1, 8'd0);
        checkIdle("single +0");
        checkOutput("single busy", 32'(busy), 32'd1);
        tick();
        checkIdle("single +1");
        tick();
        checkBeat("single", 32'h0, 32'd16, 3'd0, 3'd2, 1'b1);
        checkIdle("single done");
        checkOutput("single idle busy", 32'(busy), 32'd0);

        // INCR4 write
        for (int i = 0; i < 4; i++) pushData(32'(i + 1));
        applyStimulus(32'h10, 3'd3, 3'd2, 1'b1, 8'd0);
        tick();
        tick();
        for (int i = 0; i < 4; i++)
            checkBeat($sformatf("incr4 b%0d", i), 32'h10 + 32'(4 * i), 32'(i + 1), 3'd3, 3'd2, 1'b1);
        checkIdle("incr4 done");

        // WRAP4 write
        for (int i = 0; i < 4; i++) pushData(32'hA0 + 32'(i));
        applyStimulus(32'h14, 3'd2, 3'd2, 1'b1, 8'd0);
        tick();
        tick();
        for (int i = 0; i < 4; i++)
            checkBeat($sformatf("wrap4 b%0d", i), exp_w4[i], 32'hA0 + 32'(i), 3'd2, 3'd2, 1'b1);
        checkIdle("wrap4 done");

        // WRAP8 read
        applyStimulus(32'h34, 3'd4, 3'd2, 1'b0, 8'd0);
        tick();
        tick();
        for (int i = 0; i < 8; i++)
            checkBeat($sformatf("wrap8 b%0d", i), exp_w8[i], 32'd0, 3'd4, 3'd2, 1'b0);
        checkIdle("wrap8 done");

        // INCR of 10 beats with only 5 write beats available up front
        for (int i = 0; i < 5; i++) pushData(32'd100 + 32'(i));
        applyStimulus(32'd20, 3'd1, 3'd2, 1'b1, 8'd9);
        tick();
        tick();
        for (int i = 0; i < 5; i++)
            checkBeat($sformatf("incr10 b%0d", i), 32'd20 + 32'(4 * i), 32'd100 + 32'(i), 3'd1, 3'd2, 1'b1);
        checkIdle("incr10 starve");
        tick();
        checkIdle("incr10 wait_wd");
        checkOutput("incr10 busy", 32'(busy), 32'd1);
        HREAdy = 1'b0;
        for (int i = 5; i < 10; i++) pushData(32'd100 + 32'(i));
        HREAdy = 1'b1;
        for (int i = 5; i < 10; i++)
            checkBeat($sformatf("incr10 b%0d", i), 32'd20 + 32'(4 * i), 32'd100 + 32'(i), 3'd1, 3'd2, 1'b1);
        checkIdle("incr10 done");
        checkOutput("incr10 idle busy", 32'(busy), 32'd0);

        // INCR4 read with HREAdy low for three cycles on the second beat
        applyStimulus(32'h100, 3'd3, 3'd2, 1'b0, 8'd0);
        tick();
        tick();
        checkBeat("stall b0", 32'h100, 32'd0, 3'd3, 3'd2, 1'b0);
        HREAdy = 1'b0;
        for (int k = 0; k < 3; k++) checkBeat($sformatf("stall hold%0d", k), 32'h104, 32'd0, 3'd3, 3'd2, 1'b0);
        HREAdy = 1'b1;
        checkBeat("stall b1", 32'h104, 32'd0, 3'd3, 3'd2, 1'b0);
        checkBeat("stall b2", 32'h108, 32'd0, 3'd3, 3'd2, 1'b0);
        checkBeat("stall b3", 32'h10C, 32'd0, 3'd3, 3'd2, 1'b0);
        checkIdle("stall done");

        // Read return pipeline
        read_valid = 1'b1;
        HRUSER     = 32'h1234;
        tick();
        checkOutput("rd pulse1 valid", 32'(rd_valid), 32'd1);
        checkOutput("rd pulse1 data", rd_data, 32'h1234);
        read_valid = 1'b0;
        HRUSER     = 32'h5555;
        tick();
        checkOutput("rd gap valid", 32'(rd_valid), 32'd0);
        read_valid = 1'b1;
        HRUSER     = 32'hBEEF;
        tick();
        checkOutput("rd pulse2 valid", 32'(rd_valid), 32'd1);
        checkOutput("rd pulse2 data", rd_data, 32'hBEEF);
        read_valid = 1'b0;
        tick();

        // Back-to-back: SINGLE then INCR(2) with oversize HSIZE clamped to word
        applyStimulus(32'h200, 3'd0, 3'd2, 1'b0, 8'd0);
        applyStimulus(32'h300, 3'd1, 3'd7, 1'b0, 8'd1);
        checkIdle("b2b load");
        tick();
        checkBeat("b2b a", 32'h200, 32'd0, 3'd0, 3'd2, 1'b0);
        checkIdle("b2b bubble");
        tick();
        checkBeat("b2b b0", 32'h300, 32'd0, 3'd1, 3'd2, 1'b0);
        checkBeat("b2b b1", 32'h304, 32'd0, 3'd1, 3'd2, 1'b0);
        checkIdle("b2b done");

        // Command FIFO fill: a data-starved write holds the FSM so nothing drains
        applyStimulus(32'h0, 3'd3, 3'd2, 1'b1, 8'd0);
        tick();
        tick();
        tick();
        checkIdle("fill blocked");
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fill ready%0d", i), 32'(cmd_ready), 32'd1);
            applyStimulus(32'h400 + 32'(16 * i), 3'd0, 3'd2, 1'b0, 8'd0);
        end
        checkOutput("fill full ready", 32'(cmd_ready), 32'd0);
        applyStimulus(32'h500, 3'd0, 3'd2, 1'b0, 8'd0);
        checkOutput("fill 5th refused", 32'(cmd_ready), 32'd0);
        checkOutput("fill busy", 32'(busy), 32'd1);
        HRESET = 1'b1;
        #1;
        checkOutput("fill rst ready", 32'(cmd_ready), 32'd0);
        tick();
        checkOutput("fill rst busy", 32'(busy), 32'd0);
        HRESET = 1'b0;
        tick();
        checkOutput("fill post ready", 32'(cmd_ready), 32'd1);
        checkIdle("fill post");

        // Reset in the middle of a WRAP8 write
        for (int i = 0; i < 8; i++) pushData(32'h50 + 32'(i));
        applyStimulus(32'h34, 3'd4, 3'd2, 1'b1, 8'd0);
        tick();
        tick();
        for (int i = 0; i < 3; i++)
            checkBeat($sformatf("wrap8w b%0d", i), exp_w8[i], 32'h50 + 32'(i), 3'd4, 3'd2, 1'b1);
        checkOutput("midrst pre addr", HAUSER, 32'h20);
        HRESET = 1'b1;
        tick();
        checkIdle("midrst");
        checkOutput("midrst addr", HAUSER, 32'd0);
        checkOutput("midrst wdata", HWUSER, 32'd0);
        checkOutput("midrst hbuser", 32'(HBUSER), 32'd0);
        checkOutput("midrst hsize", 32'(HSUSER), 32'd0);
        checkOutput("midrst dir", 32'(HWSUSER), 32'd0);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("midrst wd_ready", 32'(wd_ready), 32'd0);
        HRESET = 1'b0;
        tick();
        checkOutput("postrst busy", 32'(busy), 32'd0);
        checkOutput("postrst cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("postrst wd_ready", 32'(wd_ready), 32'd1);
        checkIdle("postrst +1");
        tick();
        tick();
        checkIdle("postrst +3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
